// File: rtl/mips_debug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_debug_pkg
// Description : Shared constants and state encodings for the MIPS host debug
//               unit: command bytes, halt instruction, report length, and
//               the state types of the control FSM and the TX serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_debug_pkg;

  // Host command bytes (ASCII 'L', 'C', 'S')
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;

  // Instruction that terminates both program loading and execution
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Report = 4 bytes of PC followed by 4 bytes of cycle count
  localparam int REPORT_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    RUN       = 3'd2,
    STEP      = 3'd3,
    SEND      = 3'd4,
    SEND_WAIT = 3'd5
  } dbg_state_t;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_DRAIN = 2'd1,
    SER_ISSUE = 2'd2,
    SER_GAP   = 2'd3
  } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/debug_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : debug_tx_serializer
// Description : Sends a 64-bit report MSB byte first through a UART
//               transmitter handshake. Each byte: wait for tx_busy low,
//               strobe tx_start for one cycle, spend one mandatory gap cycle,
//               then wait for tx_busy low again. done pulses once the last
//               byte has been accepted by the transmitter.
// Ports       : clk, reset (async, active-low)
//               start  - one-cycle request, latches report
//               report - 64-bit payload, transmitted MSB byte first
//               tx_busy- transmitter busy
//               tx_data/tx_start - byte and launch strobe to transmitter
//               done   - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module debug_tx_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] report,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        done
);
  import mips_debug_pkg::*;

  ser_state_t  state, state_nxt;
  logic [63:0] shreg;
  logic [3:0]  sent;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SER_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      sent  <= '0;
    end else begin
      if (state == SER_IDLE && start) begin
        shreg <= report;
        sent  <= '0;
      end else if (state == SER_ISSUE) begin
        shreg <= {shreg[55:0], 8'h00};
        sent  <= sent + 4'd1;
      end
    end
  end

  // SER_DRAIN doubles as the pre-byte wait and the post-byte wait, so the
  // byte count decides whether another byte goes out or the report is done.
  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    done      = 1'b0;
    case (state)
      SER_IDLE: begin
        if (start) state_nxt = SER_DRAIN;
      end
      SER_DRAIN: begin
        if (!tx_busy) begin
          if (sent == 4'(REPORT_BYTES)) begin
            done      = 1'b1;
            state_nxt = SER_IDLE;
          end else begin
            state_nxt = SER_ISSUE;
          end
        end
      end
      SER_ISSUE: begin
        tx_start  = 1'b1;
        tx_data   = shreg[63:56];
        state_nxt = SER_GAP;
      end
      SER_GAP: begin
        state_nxt = SER_DRAIN;
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/debug_unit.sv
`default_nettype none
// ============================================================================
// Module      : debug_unit
// Description : Host-side control stage in front of the five-stage MIPS
//               pipeline. Loads program words received over UART into
//               instruction memory, runs the pipeline continuously or one
//               step at a time, and reports PC and cycle count back.
// Ports       : clk, reset (async, active-low)
//               rx_data/rx_valid        - received UART byte and strobe
//               tx_busy, tx_data/tx_start - UART transmitter handshake
//               imem_wr_en/addr/wr_data - instruction memory write port
//               pipe_enable, pipe_clear - pipeline advance and clear
//               halt_in, pc_in          - pipeline halt flag and fetch PC
// Revision    : 1.0 - initial release
// ============================================================================
module debug_unit #(
  parameter int              LEN       = 32,
  parameter int              ADDR_W    = 10,
  parameter logic [LEN-1:0]  HALT_WORD = mips_debug_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [LEN-1:0]    imem_wr_data,
  output logic              pipe_enable,
  output logic              pipe_clear,
  input  logic              halt_in,
  input  logic [LEN-1:0]    pc_in
);
  import mips_debug_pkg::*;

  dbg_state_t        state, state_nxt;
  logic [1:0]        byte_cnt;
  logic [LEN-9:0]    shreg;      // first three bytes of the word in flight
  logic [ADDR_W-1:0] addr_cnt;
  logic [LEN-1:0]    cyc_cnt;
  logic [LEN-1:0]    pc_latch;
  logic              ser_start;
  logic              ser_done;
  logic              load_cmd;
  logic              write_last;
  logic              enter_send;

  assign load_cmd   = (state == IDLE) && rx_valid && (rx_data == CMD_LOAD);
  // Evaluated during the write cycle: HALT ends the program, and the top
  // address ends it too because the counter must not wrap onto word 0.
  assign write_last = imem_wr_en &&
                      ((imem_wr_data == HALT_WORD) || (addr_cnt == {ADDR_W{1'b1}}));
  assign enter_send = ((state == RUN) && halt_in) || (state == STEP);
  assign imem_addr  = addr_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pipe_enable = 1'b0;
    ser_start   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_LOAD)      state_nxt = LOAD;
          else if (rx_data == CMD_CONT) state_nxt = RUN;
          else if (rx_data == CMD_STEP) state_nxt = STEP;
        end
      end
      LOAD: begin
        if (write_last) state_nxt = IDLE;
      end
      RUN: begin
        if (halt_in) state_nxt = SEND;
        else         pipe_enable = 1'b1;
      end
      STEP: begin
        // A pipeline already halted gets no enable pulse.
        pipe_enable = !halt_in;
        state_nxt   = SEND;
      end
      SEND: begin
        ser_start = 1'b1;
        state_nxt = SEND_WAIT;
      end
      SEND_WAIT: begin
        if (ser_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_clear   <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_data <= '0;
      addr_cnt     <= '0;
      byte_cnt     <= '0;
      shreg        <= '0;
      cyc_cnt      <= '0;
      pc_latch     <= '0;
    end else begin
      pipe_clear <= load_cmd;
      imem_wr_en <= 1'b0;
      if (load_cmd) begin
        addr_cnt <= '0;
        cyc_cnt  <= '0;
        byte_cnt <= '0;
        shreg    <= '0;
      end else begin
        if (state == LOAD && rx_valid) begin
          shreg    <= {shreg[LEN-17:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            imem_wr_en   <= 1'b1;
            imem_wr_data <= {shreg, rx_data};
          end
        end
        // Address advances after the write cycle has presented it.
        if (imem_wr_en)  addr_cnt <= addr_cnt + ADDR_W'(1);
        if (pipe_enable) cyc_cnt  <= cyc_cnt + LEN'(1);
      end
      if (enter_send) pc_latch <= pc_in;
    end
  end

  debug_tx_serializer u_ser (
    .clk      (clk),
    .reset    (reset),
    .start    (ser_start),
    .report   ({pc_latch, cyc_cnt}),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .done     (ser_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_debug_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_unit
// Description : Scoreboard bench for debug_unit. Stimulus pushes expected
//               memory writes and report bytes into queues; a monitor pops
//               and compares whenever the DUT strobes imem_wr_en or tx_start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_unit;
  localparam int LEN    = 32;
  localparam int ADDR_W = 2;

  localparam logic [7:0] B_LOAD = 8'h4C;
  localparam logic [7:0] B_CONT = 8'h43;
  localparam logic [7:0] B_STEP = 8'h53;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [LEN-1:0]    imem_wr_data;
  logic              pipe_enable;
  logic              pipe_clear;
  logic              halt_in;
  logic [LEN-1:0]    pc_in;

  always #5 clk = ~clk;

  debug_unit #(.LEN(LEN), .ADDR_W(ADDR_W), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_busy      (tx_busy),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .imem_wr_en   (imem_wr_en),
    .imem_addr    (imem_addr),
    .imem_wr_data (imem_wr_data),
    .pipe_enable  (pipe_enable),
    .pipe_clear   (pipe_clear),
    .halt_in      (halt_in),
    .pc_in        (pc_in)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  wr_t        mon_wr;
  int checks   = 0;
  int errors   = 0;
  int en_cnt   = 0;
  int clr_cnt  = 0;
  int tx_cnt   = 0;
  int busy_len = 2;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (pipe_enable === 1'b1) en_cnt++;
    if (pipe_clear === 1'b1)  clr_cnt++;
    if (imem_wr_en === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL imem_wr_unexpected: addr=%0d data=%h, required no write", imem_addr, imem_wr_data);
      end else begin
        mon_wr = exp_wr.pop_front();
        check("imem_addr", 64'(imem_addr), 64'(mon_wr.addr));
        check("imem_wr_data", 64'(imem_wr_data), 64'(mon_wr.data));
      end
    end
    if (tx_start === 1'b1) begin
      tx_cnt++;
      check("tx_busy_at_start", 64'(tx_busy), 64'd0);
      if (exp_tx.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: byte=%h, required no strobe", tx_data);
      end else begin
        check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
      end
    end
  end

  // Transmitter model: goes busy after each strobe for busy_len cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic push_report(input logic [31:0] pc, input logic [31:0] cyc);
    logic [63:0] r;
    r = {pc, cyc};
    for (int i = 7; i >= 0; i--) exp_tx.push_back(r[i*8 +: 8]);
  endtask

  task automatic wait_tx_empty(input string name, input int limit);
    int n;
    n = 0;
    while (exp_tx.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    check({name, "_report_complete"}, 64'(exp_tx.size()), 64'd0);
    exp_tx.delete();
    repeat (busy_len + 8) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_en, base_tx, base_clr, k, n;
    reset    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    halt_in  = 1'b0;
    pc_in    = '0;

    repeat (3) @(posedge clk); #1;
    check("reset_outputs", 64'({tx_data, tx_start, imem_wr_en, imem_addr,
                                imem_wr_data, pipe_enable, pipe_clear}), 64'd0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);

    // Load two words, the second being HALT
    exp_wr.push_back('{addr: 2'd0, data: 32'h2001_0005});
    exp_wr.push_back('{addr: 2'd1, data: 32'hFFFF_FFFF});
    send_byte(B_LOAD);
    send_word(32'h2001_0005);
    send_word(32'hFFFF_FFFF);
    repeat (4) @(posedge clk);
    check("load_writes_done", 64'(exp_wr.size()), 64'd0);
    check("load_clear_pulse", 64'(clr_cnt), 64'd1);
    check("load_no_enable", 64'(en_cnt), 64'd0);
    send_byte(8'h20);                       // stray byte in IDLE: no write
    repeat (4) @(posedge clk);

    // Unknown command then step; PC changes after SEND entry
    pc_in = 32'h0040_0010;
    send_byte(8'h41);
    repeat (4) @(posedge clk);
    check("unknown_cmd_no_enable", 64'(en_cnt), 64'd0);
    check("unknown_cmd_no_strobe", 64'(tx_cnt), 64'd0);
    push_report(32'h0040_0010, 32'd1);
    send_byte(B_STEP);
    pc_in = 32'hDEAD_BEEF;
    wait_tx_empty("step", 500);
    check("step_enable_cycles", 64'(en_cnt), 64'd1);
    check("step_strobes", 64'(tx_cnt), 64'd8);

    // Reload (clears cycle count), then continuous run for 17 cycles
    exp_wr.push_back('{addr: 2'd0, data: 32'hFFFF_FFFF});
    send_byte(B_LOAD);
    send_word(32'hFFFF_FFFF);
    repeat (4) @(posedge clk);
    check("reload_writes_done", 64'(exp_wr.size()), 64'd0);
    check("reload_clear_pulse", 64'(clr_cnt), 64'd2);
    pc_in   = 32'h0000_0044;
    base_en = en_cnt;
    push_report(32'h0000_0044, 32'h0000_0011);
    @(posedge clk); #1;
    rx_data = B_CONT; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'h00;
    k = 0; n = 0;
    while (k < 17 && n < 100) begin
      @(negedge clk);
      if (pipe_enable === 1'b1) k++;
      n++;
    end
    check("run_enabled_before_halt", 64'(k), 64'd17);
    @(posedge clk); #1 halt_in = 1'b1;
    @(negedge clk);
    check("run_enable_drops", 64'(pipe_enable), 64'd0);
    wait_tx_empty("run", 500);
    check("run_enable_cycles", 64'(en_cnt - base_en), 64'd17);

    // Halt already asserted on entry: no enable, count unchanged
    pc_in   = 32'h0000_0050;
    base_en = en_cnt;
    push_report(32'h0000_0050, 32'h0000_0011);
    send_byte(B_STEP);
    wait_tx_empty("step_halted", 500);
    push_report(32'h0000_0050, 32'h0000_0011);
    send_byte(B_CONT);
    wait_tx_empty("run_halted", 500);
    check("halted_entry_no_enable", 64'(en_cnt - base_en), 64'd0);
    halt_in = 1'b0;

    // Handshake with a slow transmitter; a command during SEND is dropped
    busy_len = 50;
    pc_in    = 32'h0BAD_F00D;
    base_en  = en_cnt;
    base_tx  = tx_cnt;
    base_clr = clr_cnt;
    push_report(32'h0BAD_F00D, 32'h0000_0012);
    send_byte(B_STEP);
    n = 0;
    while (tx_cnt < base_tx + 1 && n < 200) begin
      @(posedge clk);
      n++;
    end
    send_byte(B_LOAD);
    wait_tx_empty("handshake", 3000);
    busy_len = 2;
    check("handshake_strobes", 64'(tx_cnt - base_tx), 64'd8);
    check("handshake_cmd_dropped", 64'(clr_cnt - base_clr), 64'd0);
    check("handshake_enable", 64'(en_cnt - base_en), 64'd1);

    // Address exhaustion: 4 writes, the 5th word falls into IDLE
    exp_wr.push_back('{addr: 2'd0, data: 32'h1111_1111});
    exp_wr.push_back('{addr: 2'd1, data: 32'h2222_2222});
    exp_wr.push_back('{addr: 2'd2, data: 32'h3333_3333});
    exp_wr.push_back('{addr: 2'd3, data: 32'h4444_4444});
    base_en = en_cnt;
    base_tx = tx_cnt;
    send_byte(B_LOAD);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    send_word(32'h4444_4444);
    send_word(32'h0102_0304);
    repeat (4) @(posedge clk);
    check("exhaust_writes_done", 64'(exp_wr.size()), 64'd0);
    check("exhaust_clear_pulse", 64'(clr_cnt), 64'd3);
    check("exhaust_bytes_ignored", 64'({en_cnt - base_en, tx_cnt - base_tx}), 64'd0);
    pc_in = 32'h0000_0100;
    push_report(32'h0000_0100, 32'd1);
    send_byte(B_STEP);
    wait_tx_empty("after_exhaust", 500);

    // Reset in the middle of a report
    pc_in   = 32'h0000_0200;
    base_tx = tx_cnt;
    push_report(32'h0000_0200, 32'd2);
    send_byte(B_STEP);
    n = 0;
    while (tx_cnt < base_tx + 3 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1 reset = 1'b0;
    #1;
    check("reset_mid_send_outputs", 64'({tx_data, tx_start, imem_wr_en, imem_addr,
                                         imem_wr_data, pipe_enable, pipe_clear}), 64'd0);
    check("reset_mid_send_bytes_left", 64'(exp_tx.size()), 64'd5);
    exp_tx.delete();
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    pc_in   = 32'h0000_0300;
    base_tx = tx_cnt;
    push_report(32'h0000_0300, 32'd1);
    send_byte(B_STEP);
    wait_tx_empty("after_reset", 500);
    check("after_reset_strobes", 64'(tx_cnt - base_tx), 64'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- Host-side control stage that sits upstream of the five-stage MIPS pipeline top and feeds it.
- Receives command and program bytes from a UART receiver and writes 32-bit instructions into instruction memory.
- Gates the pipeline clock-enable in continuous or single-step mode.
- Returns PC and cycle count to the host through a UART transmitter handshake.

Parameters:
- LEN, 32, instruction/data word width (bits).
- ADDR_W, 10, instruction memory word-address width.
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that terminates loading and execution.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_busy  in  1  transmitter busy; a new byte may be issued only when low.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle strobe launching tx_data.
- imem_wr_en  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  instruction memory word address.
- imem_wr_data  out  LEN  instruction word to write.
- pipe_enable  out  1  pipeline advance enable (1 = pipeline clocks this cycle).
- pipe_clear  out  1  one-cycle synchronous clear request to pipeline registers/PC.
- halt_in  in  1  pipeline reports HALT_WORD has reached write-back.
- pc_in  in  LEN  current fetch PC from the pipeline.

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; address counter, byte counter, cycle counter and shift register = 0.
- Command bytes are accepted only in IDLE: 8'h4C 'L' = load, 8'h43 'C' = continuous, 8'h53 'S' = step.
  - Any other byte in IDLE is ignored; state stays IDLE.
  - rx_valid in RUN/STEP/SEND states is ignored (byte dropped).
- LOAD:
  - On entry: address counter=0, cycle counter=0, pipe_clear pulses for 1 cycle.
  - Bytes assembled MSB-first: 1st byte → bits [31:24] … 4th byte → [7:0].
  - On the 4th byte, the cycle after that rx_valid: imem_wr_en=1 for exactly 1 cycle, imem_addr=counter, imem_wr_data=assembled word; counter then increments.
  - Exit to IDLE after writing HALT_WORD, or after writing address 2^ADDR_W−1 (no wrap, no further writes).
- RUN ('C'):
  - pipe_enable=1 every cycle; cycle counter +1 per enabled cycle (32-bit, wraps mod 2^32).
  - When halt_in=1 is sampled: pipe_enable=0 from the next cycle; go to SEND.
  - If halt_in is already 1 on entry: zero enabled cycles, go directly to SEND.
- STEP ('S'):
  - pipe_enable=1 for exactly one cycle (cycle counter +1), then SEND.
  - If halt_in=1 at entry: no enable pulse, go directly to SEND.
- SEND: 8-byte report = pc_in sampled at entry to SEND (MSB first), then cycle counter (MSB first).
  - Per byte: wait tx_busy=0 → tx_start=1 one cycle with tx_data → one mandatory wait cycle → wait tx_busy=0.
  - After the 8th byte completes → IDLE.
- pipe_enable is never 1 in IDLE, LOAD or SEND. imem_wr_en is never 1 outside LOAD.
- Asynchronous reset mid-LOAD/RUN/SEND aborts immediately: partial word discarded, no tx_start, pipe_enable=0.

Decomposition:
- Shared package (mips_debug_pkg): command byte constants (CMD_LOAD, CMD_CONT, CMD_STEP), HALT_WORD, state encoding enum (IDLE, LOAD, RUN, STEP, SEND, SEND_WAIT), report length constant 8.
- One sub-module: debug_tx_serializer. It takes a 64-bit report plus a start pulse, drives tx_data/tx_start, and obeys the tx_busy handshake, returning done.
- Everything else lives in the top-level debug_unit FSM.

Test Plan:
- Load: after reset, send 4C, 20 01 00 05, FF FF FF FF → two writes: addr0=32'h20010005, addr1=32'hFFFFFFFF; state IDLE; no further imem_wr_en.
- Unknown command: send 8'h41 in IDLE, then 8'h53 with halt_in=0 → 8'h41 ignored; exactly one pipe_enable cycle; report bytes = pc_in sampled at SEND entry, then 00 00 00 01.
- Continuous: after load, send 43; assert halt_in after 17 enabled cycles → pipe_enable drops the next cycle; last 4 report bytes = 00 00 00 11.
- Handshake: hold tx_busy=1 for 50 cycles after each tx_start → tx_start only when tx_busy=0; exactly 8 strobes; byte order verified.
- Address exhaustion with ADDR_W=2: load 5 non-HALT words → 4 writes (addr 0..3), then IDLE; 5th word's bytes are treated as commands (none valid → ignored).
- Reset mid-SEND: reset=0 after 3 bytes sent → all outputs 0 immediately; after release, 53 produces a fresh 8-byte report with cycle count restarted at 1.
